jump_pulse_gen: RTL and testbench

JUMP_PULSE_GEN -- requirements
Module: jump_pulse_gen

---
 rtl/fsm_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/jump_pulse_gen.sv | 111 +++++++++++
 tb/tb_jump_pulse_gen.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// Shared definitions for the jump pulse generator: FSM state encoding and the
// debounce/holdoff counter type.
package fsm_pkg;

    localparam int CNT_W = 16;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS_DB = 3'd1,
        FIRE     = 3'd2,
        HOLD     = 3'd3,
        REL_DB   = 3'd4
    } state_t;

    // Terminal count for a phase lasting 'cycles' clock cycles.
    function automatic cnt_t term_count(input int unsigned cycles);
        return cnt_t'(cycles - 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/jump_pulse_gen.sv
// Debounced pushbutton to single-cycle jump pulse, with holdoff after each pulse
// and a debounced release required before the next press is accepted.
module jump_pulse_gen
    import fsm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned HOLDOFF_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_in,
    input  logic       enable,
    output logic       jump,
    output logic       busy,
    output logic       key_level,
    output logic [7:0] press_count
);

    localparam cnt_t DB_TERM = term_count(DEBOUNCE_CYCLES);
    localparam cnt_t HO_TERM = term_count(HOLDOFF_CYCLES);

    logic       key_sync;
    state_t     state_q;
    cnt_t       cnt_q;
    logic       jump_q;
    logic       busy_q;
    logic       key_level_q;
    logic [7:0] press_count_q;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (key_in),
        .q_o   (key_sync)
    );

    // Outputs are registered alongside the state so they change on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            jump_q        <= 1'b0;
            busy_q        <= 1'b0;
            key_level_q   <= 1'b0;
            press_count_q <= '0;
        end else begin
            jump_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (key_sync && enable) begin
                        state_q <= PRESS_DB;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                PRESS_DB: begin
                    if (!key_sync || !enable) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == DB_TERM) begin
                        state_q       <= FIRE;
                        cnt_q         <= '0;
                        jump_q        <= 1'b1;
                        key_level_q   <= 1'b1;
                        press_count_q <= press_count_q + 8'd1;
                    end else begin
                        cnt_q <= cnt_q + cnt_t'(1);
                    end
                end
                FIRE: begin
                    state_q <= HOLD;
                    cnt_q   <= '0;
                end
                HOLD: begin
                    if (cnt_q == HO_TERM) begin
                        state_q <= REL_DB;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + cnt_t'(1);
                    end
                end
                REL_DB: begin
                    // Any high sample restarts the release debounce window.
                    if (key_sync) begin
                        cnt_q <= '0;
                    end else if (cnt_q == DB_TERM) begin
                        state_q     <= IDLE;
                        cnt_q       <= '0;
                        busy_q      <= 1'b0;
                        key_level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + cnt_t'(1);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    busy_q      <= 1'b0;
                    key_level_q <= 1'b0;
                end
            endcase
        end
    end

    assign jump        = jump_q;
    assign busy        = busy_q;
    assign key_level   = key_level_q;
    assign press_count = press_count_q;

endmodule

// File: tb/tb_jump_pulse_gen.sv
// Scoreboard bench for jump_pulse_gen with DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=3.
module tb_jump_pulse_gen;

    localparam int DB = 4;
    localparam int HO = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_in = 1'b0;
    logic       enable = 1'b0;
    logic       jump;
    logic       busy;
    logic       key_level;
    logic [7:0] press_count;

    jump_pulse_gen #(
        .DEBOUNCE_CYCLES (DB),
        .HOLDOFF_CYCLES  (HO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .enable      (enable),
        .jump        (jump),
        .busy        (busy),
        .key_level   (key_level),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  cnt;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    int         pulses = 0;
    logic [7:0] exp_count = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every jump pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (jump === 1'b1) begin
            pulses++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_jump: got pulse at cycle %0d expected none", cyc);
            end else begin
                e = sb_q.pop_front();
                check("jump_cycle", cyc, e.cyc);
                check("jump_count", {24'd0, press_count}, {24'd0, e.cnt});
            end
        end
    end

    // Called just after a falling edge: key is sampled at the next rising edge,
    // and the pulse is visible six edges after that one.
    task automatic press_expect();
        exp_t e;
        exp_count = exp_count + 8'd1;
        e.cyc = cyc + 7;
        e.cnt = exp_count;
        sb_q.push_back(e);
        key_in = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 60);
        check({name, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got no finish by %0t expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic seen_busy;

        repeat (3) @(negedge clk);
        check("rst_jump", {31'd0, jump}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_key_level", {31'd0, key_level}, 32'd0);
        check("rst_press_count", {24'd0, press_count}, 32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clk);

        // Clean press; enable dropped in FIRE must not abort the sequence
        press_expect();
        repeat (6) @(negedge clk);
        check("clean_pre_key_level", {31'd0, key_level}, 32'd0);
        check("clean_pre_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("clean_key_level", {31'd0, key_level}, 32'd1);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        check("clean_hold_busy", {31'd0, busy}, 32'd1);
        check("clean_hold_key_level", {31'd0, key_level}, 32'd1);
        key_in = 1'b0;
        repeat (5) @(negedge clk);
        check("clean_rel_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("clean_idle_busy", {31'd0, busy}, 32'd0);
        check("clean_idle_key_level", {31'd0, key_level}, 32'd0);
        enable = 1'b1;
        repeat (3) @(negedge clk);

        // Bounce 1,0,1,0 then hold
        key_in = 1'b1;
        @(negedge clk);
        key_in = 1'b0;
        @(negedge clk);
        key_in = 1'b1;
        @(negedge clk);
        key_in = 1'b0;
        @(negedge clk);
        press_expect();
        repeat (12) @(negedge clk);
        key_in = 1'b0;
        wait_idle("bounce");

        // Long hold: one pulse only
        press_expect();
        repeat (200) @(negedge clk);
        check("held_busy", {31'd0, busy}, 32'd1);
        check("held_key_level", {31'd0, key_level}, 32'd1);
        key_in = 1'b0;
        repeat (5) @(negedge clk);
        check("held_rel_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("held_idle_busy", {31'd0, busy}, 32'd0);

        // Enable gating while pressed
        enable    = 1'b0;
        key_in    = 1'b1;
        seen_busy = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen_busy = seen_busy | busy;
        end
        check("gated_busy", {31'd0, seen_busy}, 32'd0);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        check("gated_pressdb_busy", {31'd0, busy}, 32'd1);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("gated_abort_busy", {31'd0, busy}, 32'd0);
        check("gated_abort_key_level", {31'd0, key_level}, 32'd0);
        key_in = 1'b0;
        enable = 1'b1;
        repeat (4) @(negedge clk);

        // Reset during FIRE, then full debounce after release with key held
        press_expect();
        repeat (7) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_jump", {31'd0, jump}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_key_level", {31'd0, key_level}, 32'd0);
        check("midrst_press_count", {24'd0, press_count}, 32'd0);
        exp_count = 8'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        press_expect();
        repeat (12) @(negedge clk);
        key_in = 1'b0;
        wait_idle("midrst");

        // Wrap: 256 presses from a fresh reset
        rst_n = 1'b0;
        exp_count = 8'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        begin : wrap
            int p0;
            p0 = pulses;
            for (int i = 0; i < 256; i++) begin
                press_expect();
                repeat (10) @(negedge clk);
                key_in = 1'b0;
                wait_idle("wrap");
            end
            check("wrap_press_count", {24'd0, press_count}, 32'd0);
            check("wrap_pulses", pulses - p0, 32'd256);
        end

        repeat (10) @(negedge clk);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
